alu_arbiter_seq: RTL and testbench

- Shares the single registered ALU between two requesters (req0: execute stage, req1: memory/address unit).
- Each request uses a valid/ready handshake. The block arbitrates round-robin and issues one operation at a time.
- It drives the ALU select and operand inputs, waits out the ALU's registered latency, captures Res1/Res2, and returns one tagged response on a shared response channel.
- It holds the ALU on NOP whenever the ALU is not in use.

---
 rtl/alu_arbiter_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: shares one registered ALU between two requesters.
// Round-robin grant in IDLE, one operation in flight, tagged response.
// The ALU is held on NOP whenever no operation is being issued.
// Optional build macro: ALU_ARB_DIVZERO_CHK_EN (DIV by zero answered
// locally with err=1, lo=all-ones, hi=a, and never issued to the ALU).
//
// Handshake rule for every channel here: a transfer happens on the rising
// edge where valid && ready are both high; valid must not depend on ready,
// and ready is only ever high while the controller is IDLE.
module alu_arbiter_seq #(
  parameter int ALU_LAT = 1,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_lo,
  output logic [W-1:0] rsp_hi,
  output logic         rsp_err,
  output logic [3:0]   alu_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_res1,
  input  logic [W-1:0] alu_res2,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t         state, state_nxt;
  logic           last_grant;
  logic           gnt_valid, gnt_id;
  logic [3:0]     sel_op;
  logic [W-1:0]   sel_a, sel_b;
  logic           op_nop, op_legal, op_divz, op_direct;
  logic [3:0]     op_q;
  logic [CNT_W-1:0] wait_cnt;

  // Round-robin grant: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_grant;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_valid && !gnt_id;
  assign req1_ready = gnt_valid &&  gnt_id;

  assign sel_op = gnt_id ? req1_op : req0_op;
  assign sel_a  = gnt_id ? req1_a  : req0_a;
  assign sel_b  = gnt_id ? req1_b  : req0_b;

  // Decode the granted opcode: direct responses skip the ALU entirely.
  always_comb begin
    op_nop   = (sel_op == OP_NOP);
    op_legal = (sel_op == OP_ADD) || (sel_op == OP_DIV) ||
               (sel_op == OP_SUB) || (sel_op == OP_MUL);
`ifdef ALU_ARB_DIVZERO_CHK_EN
    op_divz  = (sel_op == OP_DIV) && (sel_b == '0);
`else
    op_divz  = 1'b0;
`endif
    op_direct = !op_legal || op_divz;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (gnt_valid) state_nxt = op_direct ? RESP : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (wait_cnt == '0) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU drive, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel    <= OP_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_lo     <= '0;
      rsp_hi     <= '0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= OP_NOP;
      wait_cnt   <= '0;
    end else begin
      alu_sel <= OP_NOP;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            last_grant <= gnt_id;
            rsp_id     <= gnt_id;
            op_q       <= sel_op;
            if (op_direct) begin
              rsp_lo  <= op_divz ? '1 : '0;
              rsp_hi  <= op_divz ? sel_a : '0;
              rsp_err <= !op_nop;
            end else begin
              alu_sel <= sel_op;
              alu_a   <= sel_a;
              alu_b   <= sel_b;
            end
          end
        end
        ISSUE: wait_cnt <= CNT_W'(ALU_LAT - 1);
        WAIT: begin
          if (wait_cnt == '0) begin
            // ADD/SUB leave Res2 untouched in the ALU, so never forward it.
            rsp_lo  <= alu_res1;
            rsp_hi  <= ((op_q == OP_MUL) || (op_q == OP_DIV)) ? alu_res2 : '0;
            rsp_err <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: directed table plus hand-written corner sequences
// for alu_arbiter_seq (ALU_LAT=1, W=8) with a behavioural registered ALU.
module tb_alu_arbiter_seq;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_lo, rsp_hi;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_a, alu_b, alu_res1, alu_res2;
  logic         busy;
  logic [1:0]   state_dbg;

  alu_arbiter_seq #(.ALU_LAT(1), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res1(alu_res1), .alu_res2(alu_res2),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Registered ALU, one edge of latency; unused result registers hold.
  always @(posedge clk) begin
    case (alu_sel)
      4'd3: alu_res1 <= alu_a + alu_b;
      4'd6: alu_res1 <= alu_a - alu_b;
      4'd7: {alu_res2, alu_res1} <= alu_a * alu_b;
      4'd4: begin
        if (alu_b != 0) begin
          alu_res1 <= alu_a / alu_b;
          alu_res2 <= alu_a % alu_b;
        end else begin
          alu_res1 <= 8'hFF;
          alu_res2 <= alu_a;
        end
      end
      default: ;
    endcase
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int sel_active_cnt = 0;
  int sel4_cnt = 0;
  logic [17:0] exp_q[$];   // {id, err, hi, lo}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / monitor, sampled mid-cycle after the driver has settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (req0_ready || req1_ready)
        check("ready_rule", 32'({busy, req0_ready & req1_ready}), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got id=%0d lo=%0h hi=%0h err=%0d expected none",
                   rsp_id, rsp_lo, rsp_hi, rsp_err);
        end else begin
          check("rsp_fields", 32'({rsp_id, rsp_err, rsp_hi, rsp_lo}), 32'(exp_q.pop_front()));
        end
      end
      if (alu_sel != 4'd0) sel_active_cnt++;
      if (alu_sel == 4'd4) sel4_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one request and hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [7:0] a, b, lo, hi;
    logic       err;
    logic       issue;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic id, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] lo, input logic [7:0] hi,
                              input logic err, input logic issue);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.err = err; v.issue = issue;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    vecs.push_back(mk(0, 4'd3, 8'd200, 8'd100, 8'd44,  8'h00, 0, 1));
    vecs.push_back(mk(1, 4'd7, 8'd20,  8'd15,  8'h2C,  8'h01, 0, 1));
    vecs.push_back(mk(1, 4'd3, 8'd1,   8'd1,   8'd2,   8'h00, 0, 1));
    vecs.push_back(mk(0, 4'd6, 8'd9,   8'd4,   8'd5,   8'h00, 0, 1));
    vecs.push_back(mk(1, 4'd4, 8'd17,  8'd5,   8'd3,   8'd2,  0, 1));
    vecs.push_back(mk(0, 4'd0, 8'd5,   8'd6,   8'd0,   8'd0,  0, 0));
    vecs.push_back(mk(1, 4'hA, 8'd9,   8'd9,   8'd0,   8'd0,  1, 0));
    vecs.push_back(mk(0, 4'd6, 8'd3,   8'd5,   8'hFE,  8'h00, 0, 1));
    vecs.push_back(mk(0, 4'd7, 8'd255, 8'd255, 8'h01,  8'hFE, 0, 1));
    vecs.push_back(mk(1, 4'd4, 8'd200, 8'd7,   8'h1C,  8'h04, 0, 1));
    vecs.push_back(mk(0, 4'hF, 8'd1,   8'd2,   8'd0,   8'd0,  1, 0));
    vecs.push_back(mk(0, 4'd3, 8'd255, 8'd1,   8'd0,   8'h00, 0, 1));
`ifdef ALU_ARB_DIVZERO_CHK_EN
    vecs.push_back(mk(0, 4'd4, 8'd7,   8'd0,   8'hFF,  8'h07, 1, 0));
`endif

    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b1;
    do_reset();

    // Reset state.
    #1;
    check("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_err}), 32'd0);
    check("rst_busy", 32'({busy, state_dbg, req0_ready, req1_ready}), 32'd0);

    // Table: one request at a time, zero-wait response consumer.
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].id, vecs[i].err, vecs[i].hi, vecs[i].lo});
      sel_active_cnt = 0;
      sel4_cnt = 0;
      send(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      if (vecs[i].issue) begin
        check("issue_sel", 32'(alu_sel), 32'(vecs[i].op));
        check("issue_ops", 32'({alu_a, alu_b}), 32'({vecs[i].a, vecs[i].b}));
        check("issue_novalid", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        check("wait_sel_nop", 32'({alu_sel, rsp_valid, busy}), 32'd1);
        @(negedge clk); #1;
        check("resp_valid", 32'(rsp_valid), 32'd1);
        drain("drain_vec");
      end else begin
        check("direct_sel", 32'(alu_sel), 32'd0);
        check("direct_valid", 32'(rsp_valid), 32'd1);
        drain("drain_vec");
        check("direct_no_issue", 32'(sel_active_cnt + sel4_cnt), 32'd0);
      end
    end

    // Both requesters valid every cycle: grants alternate starting with req0.
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 8'd0, 8'd5});
    exp_q.push_back({1'b1, 1'b0, 8'd2, 8'd3});
    exp_q.push_back({1'b0, 1'b0, 8'd0, 8'd5});
    exp_q.push_back({1'b1, 1'b0, 8'd2, 8'd3});
    begin
      int grants = 0;
      @(negedge clk);
      req0_valid = 1; req0_op = 4'd6; req0_a = 8'd9;  req0_b = 8'd4;
      req1_valid = 1; req1_op = 4'd4; req1_a = 8'd17; req1_b = 8'd5;
      for (int c = 0; c < 40 && grants < 4; c++) begin
        #1;
        if (req0_ready || req1_ready) grants++;
        @(negedge clk);
      end
      req0_valid = 0;
      req1_valid = 0;
      check("rr_grants", 32'(grants), 32'd4);
      drain("drain_rr");
    end

    // Back-pressure: response held for 10 cycles while both requesters wait.
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'd0, 8'd30});
    send(0, 4'd3, 8'd10, 8'd20);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1; req0_op = 4'($urandom_range(0, 15));
      req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
      req1_valid = 1; req1_op = 4'($urandom_range(0, 15));
      req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
      #1;
      check("bp_hold", 32'({rsp_valid, rsp_id, rsp_err, rsp_hi, rsp_lo}), 32'({1'b1, 1'b0, 1'b0, 8'd0, 8'd30}));
      check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
    end
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_release", 32'({busy, rsp_valid, state_dbg}), 32'd0);
    check("bp_consumed", 32'(exp_q.size()), 32'd0);

    // Reset during WAIT aborts with no response.
    @(negedge clk);
    send(0, 4'd7, 8'd3, 8'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_state", 32'({rsp_valid, busy, alu_sel}), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_idle", 32'({busy, rsp_valid}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
